// File: rtl/temp_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : temp_mon_pkg                                                     |
// | Purpose : Constants and FSM state type shared by the temperature scan      |
// |           sequencer and its serial divider.                                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package temp_mon_pkg;

  localparam int NR_SENSORS = 5;                   // sensor slots polled per scan
  localparam int DATA_W     = 8;                   // one sensor reading
  localparam int SUM_W      = 16;                  // datapath sum width
  localparam int CNT_W      = 8;                   // datapath active-count width
  localparam int IDX_W      = $clog2(NR_SENSORS);  // sensor index width

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEL    = 3'd1,
    REQ    = 3'd2,
    NEXT   = 3'd3,
    SAMPLE = 3'd4,
    DIV    = 3'd5,
    FIN    = 3'd6
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/temp_div_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : temp_div_serial                                                  |
// | Purpose : 16/8 unsigned restoring divider, one quotient bit per cycle.     |
// |           A start pulse loads the operands; done_o is high during the      |
// |           16th cycle after the load edge, with quotient_o already holding  |
// |           the final result in that cycle. Divisor must be non-zero.        |
// | Ports   : clk_i, rst_i (async, active high), start_i, dividend_i[15:0],    |
// |           divisor_i[7:0], done_o, quotient_o[15:0]                         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module temp_div_serial
  import temp_mon_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             done_o,
  output logic [SUM_W-1:0] quotient_o
);

  localparam int             STEP_W    = $clog2(SUM_W);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SUM_W - 1);

  logic [SUM_W-1:0]  quo, quo_nxt;
  logic [CNT_W-1:0]  rem, rem_nxt, dvs;
  logic [STEP_W-1:0] step;
  logic              running;
  logic [CNT_W:0]    trial, diff;

  // One restoring step. The partial remainder is always below the divisor,
  // so the trial value fits in CNT_W+1 bits and the borrow bit of the
  // subtraction alone tells whether the divisor fits.
  always_comb begin
    trial = {rem, quo[SUM_W-1]};
    diff  = trial - {1'b0, dvs};
    if (!diff[CNT_W]) begin
      rem_nxt = diff[CNT_W-1:0];
      quo_nxt = {quo[SUM_W-2:0], 1'b1};
    end else begin
      rem_nxt = trial[CNT_W-1:0];
      quo_nxt = {quo[SUM_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      step    <= '0;
      running <= 1'b0;
    end else if (start_i) begin
      quo     <= dividend_i;
      rem     <= '0;
      dvs     <= divisor_i;
      step    <= '0;
      running <= 1'b1;
    end else if (running) begin
      quo  <= quo_nxt;
      rem  <= rem_nxt;
      step <= step + 1'b1;
      if (step == STEP_LAST) running <= 1'b0;
    end
  end

  // Result is exposed combinationally on the last step so the caller can
  // capture it on the same edge that completes the division.
  assign done_o     = running && (step == STEP_LAST);
  assign quotient_o = quo_nxt;

endmodule
`default_nettype wire

// File: rtl/temp_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : temp_scan_ctrl                                                   |
// | Purpose : Polls up to five temperature sensors over a req/ack handshake,   |
// |           packs the readings for the summing datapath, reads back sum and  |
// |           active count, and computes the truncated mean serially.          |
// | Ports   : clk_i, rst_i (async, active high), start_i, sensors_mask_i[4:0], |
// |           sensor_req_o[4:0], sensor_ack_i, sensor_val_i[7:0],              |
// |           sensors_data_o[39:0], sensors_en_o[4:0], temp_sum_i[15:0],       |
// |           nr_active_sensors_i[7:0], avg_temp_o[7:0], timeout_o[4:0],       |
// |           busy_o, done_o, err_o                                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module temp_scan_ctrl
  import temp_mon_pkg::*;
#(
  parameter int TIMEOUT = 15  // max wait cycles for an ack, must be >= 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [NR_SENSORS-1:0]        sensors_mask_i,
  output logic [NR_SENSORS-1:0]        sensor_req_o,
  input  logic                         sensor_ack_i,
  input  logic [DATA_W-1:0]            sensor_val_i,
  output logic [NR_SENSORS*DATA_W-1:0] sensors_data_o,
  output logic [NR_SENSORS-1:0]        sensors_en_o,
  input  logic [SUM_W-1:0]             temp_sum_i,
  input  logic [CNT_W-1:0]             nr_active_sensors_i,
  output logic [DATA_W-1:0]            avg_temp_o,
  output logic [NR_SENSORS-1:0]        timeout_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int                    WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NR_SENSORS - 1);
  localparam logic [NR_SENSORS-1:0] ONE_HOT0  = NR_SENSORS'(1);

  scan_state_e state, state_nxt;

  logic [NR_SENSORS-1:0]             mask;
  logic [IDX_W-1:0]                  idx;
  logic [WAIT_W-1:0]                 wait_cnt;
  logic [NR_SENSORS-1:0][DATA_W-1:0] data;
  logic [NR_SENSORS-1:0]             en;
  logic [NR_SENSORS-1:0]             tmo;
  logic [DATA_W-1:0]                 avg;
  logic                              err;

  logic                              count_zero;
  logic                              wait_expired;
  logic                              div_start;
  logic                              div_done;
  logic [SUM_W-1:0]                  div_quot;

  assign count_zero   = (nr_active_sensors_i == '0);
  assign wait_expired = (wait_cnt == WAIT_LAST);
  // The divider captures sum and count on the SAMPLE->DIV edge.
  assign div_start    = (state == SAMPLE) && !count_zero;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = SEL;
      SEL:     state_nxt = mask[idx] ? REQ : NEXT;
      REQ:     if (sensor_ack_i || wait_expired) state_nxt = NEXT;
      NEXT:    state_nxt = (idx == LAST_IDX) ? SAMPLE : SEL;
      SAMPLE:  state_nxt = count_zero ? FIN : DIV;
      DIV:     if (div_done) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask     <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      data     <= '0;
      en       <= '0;
      tmo      <= '0;
      avg      <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            mask <= sensors_mask_i;
            idx  <= '0;
            data <= '0;
            en   <= '0;
            tmo  <= '0;
            err  <= 1'b0;
          end
        end
        SEL: wait_cnt <= '0;
        REQ: begin
          // An ack on the expiry cycle still wins over the timeout.
          if (sensor_ack_i) begin
            data[idx] <= sensor_val_i;
            en[idx]   <= 1'b1;
          end else if (wait_expired) begin
            tmo[idx]  <= 1'b1;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
          end
        end
        NEXT: if (idx != LAST_IDX) idx <= idx + 1'b1;
        SAMPLE: begin
          if (count_zero) begin
            avg <= '0;
            err <= 1'b1;
          end
        end
        DIV: begin
          // Mean of 8-bit readings cannot exceed 255; saturate defensively.
          if (div_done) avg <= (|div_quot[SUM_W-1:DATA_W]) ? '1 : div_quot[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

  temp_div_serial u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start),
    .dividend_i (temp_sum_i),
    .divisor_i  (nr_active_sensors_i),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  assign sensor_req_o   = (state == REQ) ? (ONE_HOT0 << idx) : '0;
  assign sensors_data_o = data;
  assign sensors_en_o   = en;
  assign timeout_o      = tmo;
  assign avg_temp_o     = avg;
  assign err_o          = err;
  assign busy_o         = (state != IDLE);
  assign done_o         = (state == FIN);

endmodule
`default_nettype wire

// File: tb/tb_temp_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_temp_scan_ctrl                                                |
// | Purpose : Directed self-checking bench for temp_scan_ctrl with a simple    |
// |           sensor responder and a behavioural summing datapath.             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_temp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  mask = '0;
  logic [4:0]  sensor_req;
  logic        sensor_ack;
  logic [7:0]  sensor_val;
  logic [39:0] sensors_data;
  logic [4:0]  sensors_en;
  logic [15:0] temp_sum;
  logic [7:0]  nr_active;
  logic [7:0]  avg_temp;
  logic [4:0]  timeout;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_err = 0;

  temp_scan_ctrl dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start),
    .sensors_mask_i      (mask),
    .sensor_req_o        (sensor_req),
    .sensor_ack_i        (sensor_ack),
    .sensor_val_i        (sensor_val),
    .sensors_data_o      (sensors_data),
    .sensors_en_o        (sensors_en),
    .temp_sum_i          (temp_sum),
    .nr_active_sensors_i (nr_active),
    .avg_temp_o          (avg_temp),
    .timeout_o           (timeout),
    .busy_o              (busy),
    .done_o              (done),
    .err_o               (err)
  );

  always #5 clk = ~clk;

  // Sensor responder: sensor n acks after delay[n] cycles of continuous request
  // (delay -1 means never). A stray ack can be injected independently.
  int         delay [5];
  logic [7:0] vals  [5];
  int         rcyc = 0;
  logic       resp_ack = 1'b0;
  logic [7:0] resp_val = '0;
  logic       stray_ack = 1'b0;
  logic [7:0] stray_val = '0;

  always @(negedge clk) begin
    resp_ack = 1'b0;
    resp_val = '0;
    if (sensor_req != '0) begin
      for (int n = 0; n < 5; n++)
        if (sensor_req[n] && rcyc == delay[n]) begin
          resp_ack = 1'b1;
          resp_val = vals[n];
        end
      rcyc = rcyc + 1;
    end else begin
      rcyc = 0;
    end
  end

  assign sensor_ack = resp_ack | stray_ack;
  assign sensor_val = stray_ack ? stray_val : resp_val;

  // Behavioural summing datapath
  always_comb begin
    temp_sum  = '0;
    nr_active = '0;
    for (int n = 0; n < 5; n++)
      if (sensors_en[n]) begin
        temp_sum  = temp_sum + 16'(sensors_data[n*8 +: 8]);
        nr_active = nr_active + 8'd1;
      end
  end

  int done_cnt = 0;
  int req_cnt  = 0;
  always @(negedge clk) begin
    if (done)             done_cnt++;
    if (sensor_req != '0) req_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_sensor(input int n, input logic [7:0] v, input int d);
    vals[n]  = v;
    delay[n] = d;
  endtask

  // Launches one scan and returns the cycle (start cycle = 1) in which done_o is seen.
  task automatic run_scan(input logic [4:0] m, output int lat);
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    lat   = 1;
    @(negedge clk);
    start = 1'b0;
    lat   = 2;
    check("busy_in_scan", 64'(busy), 64'd1);
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_seen", 64'(done), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  int lat, d0, r0;

  initial begin
    for (int n = 0; n < 5; n++) set_sensor(n, 8'd0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_avg", 64'(avg_temp), 64'd0);
    check("rst_en", 64'(sensors_en), 64'd0);
    check("rst_data", 64'(sensors_data), 64'd0);
    check("rst_req", 64'(sensor_req), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // 1: all sensors immediate, mean 40
    set_sensor(0, 8'd20, 0); set_sensor(1, 8'd30, 0); set_sensor(2, 8'd40, 0);
    set_sensor(3, 8'd50, 0); set_sensor(4, 8'd60, 0);
    run_scan(5'h1F, lat);
    check("t1_lat", 64'(lat), 64'd34);
    check("t1_en", 64'(sensors_en), 64'h1F);
    check("t1_avg", 64'(avg_temp), 64'd40);
    check("t1_err", 64'(err), 64'd0);
    check("t1_tmo", 64'(timeout), 64'd0);
    check("t1_data", 64'(sensors_data), 64'h3C_32_28_1E_14);

    // 2: sensor 2 silent -> timeout, +15 cycles
    for (int n = 0; n < 5; n++) set_sensor(n, 8'd100, 0);
    set_sensor(2, 8'd77, -1);
    run_scan(5'h1F, lat);
    check("t2_lat", 64'(lat), 64'd49);
    check("t2_tmo", 64'(timeout), 64'h04);
    check("t2_en", 64'(sensors_en), 64'h1B);
    check("t2_avg", 64'(avg_temp), 64'd100);
    check("t2_data", 64'(sensors_data), 64'h64_64_00_64_64);

    // 3: empty mask -> no requests, err
    r0 = req_cnt;
    d0 = done_cnt;
    run_scan(5'h00, lat);
    check("t3_lat", 64'(lat), 64'd13);
    check("t3_no_req", 64'(req_cnt - r0), 64'd0);
    check("t3_err", 64'(err), 64'd1);
    check("t3_avg", 64'(avg_temp), 64'd0);
    check("t3_en", 64'(sensors_en), 64'd0);
    check("t3_tmo", 64'(timeout), 64'd0);
    check("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

    // 4: truncation, 509/2 = 254
    set_sensor(0, 8'd255, 0); set_sensor(4, 8'd254, 0);
    run_scan(5'h11, lat);
    check("t4_lat", 64'(lat), 64'd31);
    check("t4_avg", 64'(avg_temp), 64'd254);
    check("t4_slot4", 64'(sensors_data[39:32]), 64'd254);
    check("t4_slot0", 64'(sensors_data[7:0]), 64'd255);
    check("t4_en", 64'(sensors_en), 64'h11);
    check("t4_err", 64'(err), 64'd0);
    repeat (5) @(negedge clk);
    check("t4_avg_hold", 64'(avg_temp), 64'd254);
    check("t4_en_hold", 64'(sensors_en), 64'h11);

    // 5: ack on the expiry cycle succeeds, one cycle later times out
    for (int n = 0; n < 5; n++) set_sensor(n, 8'd10, 0);
    set_sensor(1, 8'd50, 15);
    set_sensor(3, 8'd90, 16);
    run_scan(5'h1F, lat);
    check("t5_lat", 64'(lat), 64'd64);
    check("t5_en", 64'(sensors_en), 64'h17);
    check("t5_tmo", 64'(timeout), 64'h08);
    check("t5_avg", 64'(avg_temp), 64'd20);
    check("t5_data", 64'(sensors_data), 64'h0A_00_0A_32_0A);

    // 6: start re-pulse mid-scan and stray ack in NEXT are ignored
    set_sensor(0, 8'd20, 0); set_sensor(1, 8'd30, 0); set_sensor(2, 8'd40, 0);
    set_sensor(3, 8'd50, 0); set_sensor(4, 8'd60, 0);
    d0 = done_cnt;
    fork
      run_scan(5'h1F, lat);
      begin
        repeat (7) @(negedge clk);   // cycle 7: NEXT after sensor 1
        stray_val = 8'd99;
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);   // cycle 10
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (40) @(negedge clk);
    check("t6_lat", 64'(lat), 64'd34);
    check("t6_avg", 64'(avg_temp), 64'd40);
    check("t6_data", 64'(sensors_data), 64'h3C_32_28_1E_14);
    check("t6_done_cnt", 64'(done_cnt - d0), 64'd1);

    // 7: reset during DIV aborts immediately, then a clean scan
    @(negedge clk);
    mask  = 5'h1F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (23) @(negedge clk);      // cycle 25, inside DIV
    check("t7_pre_en", 64'(sensors_en), 64'h1F);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("t7_rst_busy", 64'(busy), 64'd0);
    check("t7_rst_en", 64'(sensors_en), 64'd0);
    check("t7_rst_data", 64'(sensors_data), 64'd0);
    check("t7_rst_avg", 64'(avg_temp), 64'd0);
    check("t7_rst_tmo", 64'(timeout), 64'd0);
    check("t7_rst_err", 64'(err), 64'd0);
    check("t7_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t7_no_done", 64'(done_cnt - d0), 64'd0);
    run_scan(5'h1F, lat);
    check("t7_lat", 64'(lat), 64'd34);
    check("t7_avg", 64'(avg_temp), 64'd40);
    check("t7_en", 64'(sensors_en), 64'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/temp_scan_ctrl.md
Name: temp_scan_ctrl

Overview:
- Sequencer that polls the board temperature sensors one at a time over a req/ack handshake and builds the packed data word and the enable vector for the sensor summing datapath.
- Reads back that datapath's sum and active count, then computes the mean temperature with a serial divider.
- Sits between the sensor bus and the monitoring/alarm logic. Each scan runs once per start pulse.

Parameters:
- NR_SENSORS, 5, number of sensor slots polled. Fixed at 5 to match the summing datapath.
- DATA_W, 8, width of one sensor reading.
- TIMEOUT, 15, maximum wait cycles for sensor_ack_i after a request. Must be at least 1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  single-cycle scan request
- sensors_mask_i  in  5  installed-sensor mask; sampled at scan start
- sensor_req_o  out  5  one-hot read request to sensor n
- sensor_ack_i  in  1  addressed sensor's value valid this cycle
- sensor_val_i  in  8  reading from the addressed sensor
- sensors_data_o  out  40  packed readings to datapath; slot n at [8n+7:8n]
- sensors_en_o  out  5  valid-reading vector to datapath
- temp_sum_i  in  16  sum returned from datapath
- nr_active_sensors_i  in  8  active count returned from datapath
- avg_temp_o  out  8  truncated mean of valid readings
- timeout_o  out  5  per-sensor timeout flags for the last scan
- busy_o  out  1  scan in progress
- done_o  out  1  one-cycle pulse at end of scan
- err_o  out  1  last scan produced zero valid readings

Behaviour:
- Reset, asynchronous and active-high on rst_i:
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset asserted mid-scan aborts the scan immediately. No done_o pulse is produced.
- FSM states and transitions:
  - IDLE: on start_i, latch mask, clear sensors_en_o, timeout_o, sensors_data_o and err_o, set idx=0, go to SEL.
  - SEL: if mask[idx]=0, skip to NEXT. Otherwise go to REQ.
  - REQ: drive sensor_req_o = one-hot(idx) and hold it every cycle until an ack or a timeout.
    - Wait counter starts at 0 and increments each cycle with no ack.
    - On sensor_ack_i=1: latch sensor_val_i into slot idx, set sensors_en_o[idx], go to NEXT.
    - If the counter reaches TIMEOUT with no ack: set timeout_o[idx], leave slot idx at 0 and en at 0, go to NEXT.
    - An ack on the timeout cycle itself counts as success.
  - NEXT: sensor_req_o=0. If idx=4, go to SAMPLE. Otherwise idx++ and go to SEL.
  - SAMPLE: one cycle for datapath settling, then latch temp_sum_i and nr_active_sensors_i.
    - If count=0: avg_temp_o=0, err_o=1, go to FIN.
    - Otherwise go to DIV.
  - DIV: restoring divide, 16-bit dividend by 8-bit divisor, one quotient bit per cycle, 16 cycles.
    - Quotient is truncated (no rounding).
    - Result always fits in 8 bits (at most 255). Load avg_temp_o, go to FIN.
  - FIN: done_o=1 for one cycle, go to IDLE.
- busy_o=1 in every state except IDLE.
- start_i is ignored while busy_o=1.
- sensor_ack_i is ignored outside REQ.
- Stray acks in SEL or NEXT are discarded.
- sensors_data_o, sensors_en_o, avg_temp_o, timeout_o and err_o hold their values from FIN until the next accepted start.
- Latency from start to done, all 5 sensors acking on their first request cycle: 1 (IDLE) + 5×(SEL+REQ+NEXT=3) + 1 (SAMPLE) + 16 (DIV) + 1 (FIN) = 34 cycles.
  - Each masked sensor removes 1 cycle.
  - Each timed-out sensor adds TIMEOUT cycles.
- The wait counter is 4 bits wide when TIMEOUT=15 and is cleared on entry to REQ.

Decomposition:
- Shared package temp_mon_pkg:
  - NR_SENSORS and DATA_W constants
  - FSM state enum (IDLE, SEL, REQ, NEXT, SAMPLE, DIV, FIN)
  - SUM_W=16 and CNT_W=8 constants
- One sub-module: temp_div_serial.
  - 16/8 restoring divider with start/done handshake and fixed 16-cycle latency.
  - Reused later by the alarm-threshold logic.

Test Plan:
- Mask=5'h1F, acks immediate, values 20,30,40,50,60 -> sensors_en_o=5'h1F, avg_temp_o=40, done_o at cycle 34 after start, err_o=0.
- Mask=5'h1F, sensor 2 never acks, others 100 -> timeout_o=5'h04, sensors_en_o=5'h1B, avg_temp_o=100, latency extended by exactly 15 cycles.
- Mask=5'h00 -> no sensor_req_o ever asserted, err_o=1, avg_temp_o=0, done_o pulses.
- Mask=5'h11, values 255 and 254 -> avg_temp_o=254 (truncated), sensors_data_o[39:32]=254, [7:0]=255.
- start_i re-pulsed mid-scan, plus a stray ack in NEXT -> scan unaffected, one done_o only.
- rst_i asserted during DIV -> all outputs 0 immediately. A fresh start afterwards completes a normal scan.
